// File: rtl/reorder_buffer_pkg.sv
// Shared widths and types for the reorder buffer, its query ports and its bus interface.
// The reservation station imports the same package so ROB tag widths always agree.
package reorder_buffer_pkg;

  localparam int unsigned RobWidth  = 4;
  localparam int unsigned RobSize   = 2 ** RobWidth;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned RegWidth  = 5;

  typedef logic [RobWidth-1:0]  rob_tag_t;
  typedef logic [RobWidth:0]    rob_cnt_t;
  typedef logic [DataWidth-1:0] rob_data_t;
  typedef logic [RegWidth-1:0]  arch_reg_t;

  typedef struct packed {
    logic      valid;
    rob_tag_t  tag;
    rob_data_t value;
  } wb_port_t;

  // Pointers are exactly RobWidth bits, so the increment wraps modulo RobSize by itself.
  function automatic rob_tag_t ptr_inc(input rob_tag_t ptr);
    return ptr + rob_tag_t'(1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / writeback / query / commit signal bundle of the reorder buffer.
// The master side is the pipeline around the ROB; the slave side is the ROB itself.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic      rdy_in;
  logic      flush_in;
  logic      alloc_in;
  arch_reg_t alloc_rd_in;
  rob_tag_t  alloc_tag;
  logic      full;
  logic      empty;

  logic      wb_valid_1;
  rob_tag_t  wb_tag_1;
  rob_data_t wb_value_1;
  logic      wb_valid_2;
  rob_tag_t  wb_tag_2;
  rob_data_t wb_value_2;

  rob_tag_t  query_tag_1;
  logic      query_ready_1;
  rob_data_t query_value_1;
  rob_tag_t  query_tag_2;
  logic      query_ready_2;
  rob_data_t query_value_2;

  logic      commit;
  rob_tag_t  commit_tag;
  rob_data_t commit_value;
  arch_reg_t commit_rd;

  modport master (
    output rdy_in, flush_in, alloc_in, alloc_rd_in,
    output wb_valid_1, wb_tag_1, wb_value_1, wb_valid_2, wb_tag_2, wb_value_2,
    output query_tag_1, query_tag_2,
    input  alloc_tag, full, empty,
    input  query_ready_1, query_value_1, query_ready_2, query_value_2,
    input  commit, commit_tag, commit_value, commit_rd
  );

  modport slave (
    input  rdy_in, flush_in, alloc_in, alloc_rd_in,
    input  wb_valid_1, wb_tag_1, wb_value_1, wb_valid_2, wb_tag_2, wb_value_2,
    input  query_tag_1, query_tag_2,
    output alloc_tag, full, empty,
    output query_ready_1, query_value_1, query_ready_2, query_value_2,
    output commit, commit_tag, commit_value, commit_rd
  );

endinterface

// File: rtl/reorder_buffer_query.sv
// One combinational operand lookup: stored result, or same-cycle writeback bypass.
// Port 1 takes precedence on the bypass so it matches the writeback priority.
module reorder_buffer_query
  import reorder_buffer_pkg::*;
(
  input  rob_tag_t                  query_tag_i,
  input  logic      [RobSize-1:0]   busy_i,
  input  logic      [RobSize-1:0]   ready_i,
  input  rob_data_t [RobSize-1:0]   value_i,
  input  wb_port_t                  wb1_i,
  input  wb_port_t                  wb2_i,
  output logic                      query_ready_o,
  output rob_data_t                 query_value_o
);

  logic wb1_hit, wb2_hit;

  always_comb begin
    wb1_hit       = wb1_i.valid && (wb1_i.tag == query_tag_i);
    wb2_hit       = wb2_i.valid && (wb2_i.tag == query_tag_i);
    query_ready_o = busy_i[query_tag_i] && (ready_i[query_tag_i] || wb1_hit || wb2_hit);
    query_value_o = '0;
    if (query_ready_o) begin
      if (wb1_hit) begin
        query_value_o = wb1_i.value;
      end else if (wb2_hit) begin
        query_value_o = wb2_i.value;
      end else begin
        query_value_o = value_i[query_tag_i];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, takes two ALU writebacks per cycle,
// retires at most one ready head entry per cycle and serves two operand-tag lookups.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk_in,
  input logic             rst_n_in,
  reorder_buffer_if.slave rob
);

  rob_tag_t                head_q, head_d, tail_q, tail_d;
  rob_cnt_t                count_q, count_d;
  logic      [RobSize-1:0] busy_q, busy_d, ready_q, ready_d;
  rob_data_t [RobSize-1:0] value_q, value_d;
  arch_reg_t [RobSize-1:0] rd_q, rd_d;

  logic      commit_q, commit_d;
  rob_tag_t  commit_tag_q, commit_tag_d;
  rob_data_t commit_value_q, commit_value_d;
  arch_reg_t commit_rd_q, commit_rd_d;

  logic     full, alloc_acc, commit_acc;
  wb_port_t wb1, wb2;

  assign wb1  = '{valid: rob.wb_valid_1, tag: rob.wb_tag_1, value: rob.wb_value_1};
  assign wb2  = '{valid: rob.wb_valid_2, tag: rob.wb_tag_2, value: rob.wb_value_2};
  // Occupancy comes from the registered count only; pointers alone cannot tell full from empty.
  assign full = (count_q == rob_cnt_t'(RobSize));

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    value_d        = value_q;
    rd_d           = rd_q;
    commit_d       = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;
    commit_rd_d    = commit_rd_q;
    alloc_acc      = 1'b0;
    commit_acc     = 1'b0;

    if (rob.flush_in) begin
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      busy_d         = '0;
      ready_d        = '0;
      commit_tag_d   = '0;
      commit_value_d = '0;
      commit_rd_d    = '0;
    end else if (rob.rdy_in) begin
      alloc_acc  = rob.alloc_in && !full;
      commit_acc = busy_q[head_q] && ready_q[head_q];

      if (alloc_acc) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = rob.alloc_rd_in;
        tail_d          = ptr_inc(tail_q);
      end

      // Port 2 first so port 1 overwrites it when both target the same tag.
      if (wb2.valid && busy_q[wb2.tag]) begin
        ready_d[wb2.tag] = 1'b1;
        value_d[wb2.tag] = wb2.value;
      end
      if (wb1.valid && busy_q[wb1.tag]) begin
        ready_d[wb1.tag] = 1'b1;
        value_d[wb1.tag] = wb1.value;
      end

      if (commit_acc) begin
        commit_d        = 1'b1;
        commit_tag_d    = head_q;
        commit_value_d  = value_q[head_q];
        commit_rd_d     = rd_q[head_q];
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = ptr_inc(head_q);
      end

      count_d = count_q + rob_cnt_t'(alloc_acc) - rob_cnt_t'(commit_acc);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_q       <= 1'b0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      commit_rd_q    <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_q       <= commit_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
      commit_rd_q    <= commit_rd_d;
    end
  end

  // Payload storage is qualified by busy/ready, so it needs no reset.
  always_ff @(posedge clk_in) begin
    value_q <= value_d;
    rd_q    <= rd_d;
  end

  assign rob.alloc_tag    = tail_q;
  assign rob.full         = full;
  assign rob.empty        = (count_q == '0);
  assign rob.commit       = commit_q;
  assign rob.commit_tag   = commit_tag_q;
  assign rob.commit_value = commit_value_q;
  assign rob.commit_rd    = commit_rd_q;

  reorder_buffer_query u_query_1 (
    .query_tag_i   (rob.query_tag_1),
    .busy_i        (busy_q),
    .ready_i       (ready_q),
    .value_i       (value_q),
    .wb1_i         (wb1),
    .wb2_i         (wb2),
    .query_ready_o (rob.query_ready_1),
    .query_value_o (rob.query_value_1)
  );

  reorder_buffer_query u_query_2 (
    .query_tag_i   (rob.query_tag_2),
    .busy_i        (busy_q),
    .ready_i       (ready_q),
    .value_i       (value_q),
    .wb1_i         (wb1),
    .wb2_i         (wb2),
    .query_ready_o (rob.query_ready_2),
    .query_value_o (rob.query_value_2)
  );

endmodule
